// File: rtl/wb_wait_slave_pkg.sv
// Shared types for the Wishbone wait-state slave: FSM state encoding and a
// helper that sizes the wait-state counter.
package wb_wait_slave_pkg;

  typedef enum logic [1:0] {
    SLAVE_STATE_IDLE,
    SLAVE_STATE_DELAY,
    SLAVE_STATE_RESPOND
  } slave_state_t;

  // Counter must hold ACK_DELAY itself; keep at least one bit for ACK_DELAY 0/1.
  function automatic int delay_cnt_width(input int ack_delay);
    return (ack_delay > 1) ? $clog2(ack_delay + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_wait_slave_if.sv
// Wishbone B4 classic-cycle bundle between a master and wb_wait_slave.
interface wb_wait_slave_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) ();

  logic                      cyc_i;
  logic                      stb_i;
  logic                      we_i;
  logic [ADDR_WIDTH-1:0]     adr_i;
  logic [DATA_WIDTH-1:0]     dat_i;
  logic [DATA_WIDTH/8-1:0]   sel_i;
  logic [DATA_WIDTH-1:0]     dat_o;
  logic                      ack_o;
  logic                      err_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    input  dat_o, ack_o, err_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
    output dat_o, ack_o, err_o
  );

endinterface

// File: rtl/wb_regfile.sv
// NUM_REGS x DATA_WIDTH register bank: byte-enable write port, one registered
// read port. Every register clears on reset.
module wb_regfile #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_en_i,
  input  logic [ADDR_WIDTH-1:0]   wr_addr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic [DATA_WIDTH/8-1:0] wr_sel_i,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o
);

  localparam int NB = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] reg_vals [NUM_REGS];
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  genvar gi, gb;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_q, reg_d;
      logic                  hit;

      assign hit = wr_en_i && (wr_addr_i == ADDR_WIDTH'(gi));

      for (gb = 0; gb < NB; gb++) begin : g_byte
        assign reg_d[8*gb +: 8] = (hit && wr_sel_i[gb]) ? wr_data_i[8*gb +: 8]
                                                        : reg_q[8*gb +: 8];
      end

      always_ff @(posedge clk_i) begin
        if (rst_i) reg_q <= '0;
        else       reg_q <= reg_d;
      end

      assign reg_vals[gi] = reg_q;
    end
  endgenerate

  // Out-of-range addresses read as zero; the top never exposes them anyway.
  always_comb begin
    rd_data_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_addr_i == ADDR_WIDTH'(i)) rd_data_d = reg_vals[i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/wb_wait_slave.sv
// Wishbone classic slave: register bank, programmable ack latency, status
// register counting acks at the top address, err_o for unmapped addresses.
module wb_wait_slave
  import wb_wait_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ACK_DELAY  = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  wb_wait_slave_if.slave   bus
);

  localparam int                  SW         = DATA_WIDTH / 8;
  localparam int                  CW         = delay_cnt_width(ACK_DELAY);
  localparam logic [ADDR_WIDTH:0] NREGS_L    = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] STATUS_ADR = '1;

  slave_state_t            state_q, state_d;
  logic [CW-1:0]           dly_q, dly_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
  logic [SW-1:0]           sel_q, sel_d;
  logic                    ack_q, ack_d;
  logic                    err_q, err_d;
  logic                    rd_reg_q, rd_reg_d;
  logic [DATA_WIDTH-1:0]   stat_dat_q, stat_dat_d;
  logic [DATA_WIDTH-1:0]   ack_cnt_q, ack_cnt_d;

  logic                    req, in_idle, go_respond, is_reg, is_stat, wr_en;
  logic                    cur_we;
  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic [DATA_WIDTH-1:0]   cur_dat, rf_rdata;
  logic [SW-1:0]           cur_sel;

  // With ACK_DELAY = 0 the response is decided on the sampling edge itself,
  // so the datapath looks at the live bus in IDLE and the latched copy later.
  assign req     = bus.cyc_i & bus.stb_i;
  assign in_idle = (state_q == SLAVE_STATE_IDLE);
  assign cur_we  = in_idle ? bus.we_i  : we_q;
  assign cur_adr = in_idle ? bus.adr_i : adr_q;
  assign cur_dat = in_idle ? bus.dat_i : wdat_q;
  assign cur_sel = in_idle ? bus.sel_i : sel_q;
  assign is_reg  = ({1'b0, cur_adr} < NREGS_L);
  assign is_stat = (cur_adr == STATUS_ADR);

  always_comb begin
    state_d    = state_q;
    dly_d      = dly_q;
    we_d       = we_q;
    adr_d      = adr_q;
    wdat_d     = wdat_q;
    sel_d      = sel_q;
    go_respond = 1'b0;
    case (state_q)
      SLAVE_STATE_IDLE: begin
        if (req) begin
          we_d   = bus.we_i;
          adr_d  = bus.adr_i;
          wdat_d = bus.dat_i;
          sel_d  = bus.sel_i;
          dly_d  = CW'(ACK_DELAY);
          if (ACK_DELAY == 0) begin
            state_d    = SLAVE_STATE_RESPOND;
            go_respond = 1'b1;
          end else begin
            state_d = SLAVE_STATE_DELAY;
          end
        end
      end
      SLAVE_STATE_DELAY: begin
        if (!req) begin
          state_d = SLAVE_STATE_IDLE;
        end else if (dly_q == CW'(1)) begin
          state_d    = SLAVE_STATE_RESPOND;
          go_respond = 1'b1;
        end else begin
          dly_d = dly_q - CW'(1);
        end
      end
      default: state_d = SLAVE_STATE_IDLE;
    endcase
  end

  always_comb begin
    ack_d      = go_respond & (is_reg | is_stat);
    err_d      = go_respond & ~(is_reg | is_stat);
    rd_reg_d   = go_respond & is_reg & ~cur_we;
    stat_dat_d = (go_respond & is_stat & ~cur_we) ? ack_cnt_q : '0;
    wr_en      = go_respond & is_reg & cur_we;
    // A status clear wins over the increment from its own ack.
    if (go_respond && is_stat && cur_we) ack_cnt_d = '0;
    else if (ack_d)                      ack_cnt_d = ack_cnt_q + 1'b1;
    else                                 ack_cnt_d = ack_cnt_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= SLAVE_STATE_IDLE;
      dly_q      <= '0;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdat_q     <= '0;
      sel_q      <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_reg_q   <= 1'b0;
      stat_dat_q <= '0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dly_q      <= dly_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdat_q     <= wdat_d;
      sel_q      <= sel_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      rd_reg_q   <= rd_reg_d;
      stat_dat_q <= stat_dat_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  wb_regfile #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_regfile (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en),
    .wr_addr_i (cur_adr),
    .wr_data_i (cur_dat),
    .wr_sel_i  (cur_sel),
    .rd_addr_i (cur_adr),
    .rd_data_o (rf_rdata)
  );

  assign bus.ack_o = ack_q;
  assign bus.err_o = err_q;
  assign bus.dat_o = rd_reg_q ? rf_rdata : stat_dat_q;

endmodule

// File: tb/tb_wb_wait_slave.sv
// Bench for wb_wait_slave: directed scenarios plus randomized traffic against
// a transaction-level model; a second instance covers ACK_DELAY = 0.
module tb_wb_wait_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  wb_wait_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifa ();
  wb_wait_slave_if #(.ADDR_WIDTH(4), .DATA_WIDTH(32)) ifb ();

  wb_wait_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(8), .ACK_DELAY(2))
    dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  wb_wait_slave #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_REGS(8), .ACK_DELAY(0))
    dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  // Transaction-level model of dut_a: register contents and ack count.
  logic [31:0] m_regs [8];
  logic [31:0] m_cnt;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = '0;
    m_cnt = '0;
  endtask

  task automatic model_txn(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, output logic ack, output logic err,
                           output logic [31:0] rdat);
    ack = 1'b0; err = 1'b0; rdat = '0;
    if (adr < 4'd8) begin
      ack = 1'b1;
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) m_regs[adr[2:0]][8*b +: 8] = dat[8*b +: 8];
      end else begin
        rdat = m_regs[adr[2:0]];
      end
      m_cnt = m_cnt + 1;
    end else if (adr == 4'd15) begin
      ack = 1'b1;
      if (we) m_cnt = '0;
      else begin
        rdat  = m_cnt;
        m_cnt = m_cnt + 1;
      end
    end else begin
      err = 1'b1;
    end
  endtask

  // One transaction on dut_a; reports what the bus showed, cycles from the
  // sampling edge to the response (0 = none within bound) and the next cycle.
  task automatic do_txn(input logic we, input logic [3:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, output logic ack, output logic err,
                        output logic [31:0] rdat, output int lat, output logic tail);
    @(negedge clk);
    ifa.cyc_i = 1'b1; ifa.stb_i = 1'b1; ifa.we_i = we;
    ifa.adr_i = adr;  ifa.dat_i = dat;  ifa.sel_i = sel;
    ack = 1'b0; err = 1'b0; rdat = '0; lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (ifa.ack_o || ifa.err_o) begin
        lat = i; ack = ifa.ack_o; err = ifa.err_o; rdat = ifa.dat_o;
        break;
      end
    end
    ifa.cyc_i = 1'b0; ifa.stb_i = 1'b0;
    @(posedge clk); #1;
    tail = ifa.ack_o | ifa.err_o | (ifa.dat_o != 32'd0);
    $display("[TB] txn we=%0b adr=%0d dat=%08h sel=%h -> ack=%0b err=%0b dat=%08h lat=%0d",
             we, adr, dat, sel, ack, err, rdat, lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if ({ifa.ack_o, ifa.err_o, ifa.dat_o, ifb.ack_o, ifb.err_o, ifb.dat_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: a ack/err/dat=%0b/%0b/%08h b=%0b/%0b/%08h, want all 0",
               ifa.ack_o, ifa.err_o, ifa.dat_o, ifb.ack_o, ifb.err_o, ifb.dat_o);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    logic ea, ee, a, e, t; logic [31:0] ed, d; int l;
    model_txn(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, ea, ee, ed);
    do_txn(1'b1, 4'd3, 32'hDEADBEEF, 4'hF, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || e !== 1'b0 || l != 3 || t !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_write: ack=%0b err=%0b lat=%0d tail=%0b, want 1 0 3 0", a, e, l, t);
    end
    model_txn(1'b0, 4'd3, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd3, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || d !== 32'hDEADBEEF || l != 3 || t !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_read: ack=%0b dat=%08h lat=%0d tail=%0b, want 1 deadbeef 3 0", a, d, l, t);
    end
  endtask

  task automatic test_byte_sel();
    logic ea, ee, a, e, t; logic [31:0] ed, d; int l;
    model_txn(1'b1, 4'd1, 32'h11223344, 4'hF, ea, ee, ed);
    do_txn(1'b1, 4'd1, 32'h11223344, 4'hF, a, e, d, l, t);
    model_txn(1'b1, 4'd1, 32'hAABBCCDD, 4'h5, ea, ee, ed);
    do_txn(1'b1, 4'd1, 32'hAABBCCDD, 4'h5, a, e, d, l, t);
    model_txn(1'b0, 4'd1, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd1, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || d !== 32'h11BB33DD) begin
      tests_failed++;
      $display("FAIL byte_sel: ack=%0b dat=%08h, want 1 11bb33dd", a, d);
    end
  endtask

  task automatic test_error();
    logic ea, ee, a, e, t; logic [31:0] ed, d, cnt_before; int l;
    cnt_before = m_cnt;
    model_txn(1'b0, 4'd10, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd10, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b0 || e !== 1'b1 || d !== 32'd0 || l != 3 || t !== 1'b0) begin
      tests_failed++;
      $display("FAIL error_resp: ack=%0b err=%0b dat=%08h lat=%0d tail=%0b, want 0 1 0 3 0",
               a, e, d, l, t);
    end
    model_txn(1'b0, 4'd15, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd15, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || d !== cnt_before) begin
      tests_failed++;
      $display("FAIL error_no_count: ack=%0b status=%0d, want 1 %0d", a, d, cnt_before);
    end
  endtask

  task automatic test_abort();
    logic ea, ee, a, e, t, seen; logic [31:0] ed, d; int l;
    model_txn(1'b1, 4'd2, 32'h01020304, 4'hF, ea, ee, ed);
    do_txn(1'b1, 4'd2, 32'h01020304, 4'hF, a, e, d, l, t);
    @(negedge clk);
    ifa.cyc_i = 1'b1; ifa.stb_i = 1'b1; ifa.we_i = 1'b1;
    ifa.adr_i = 4'd2; ifa.dat_i = 32'hCAFEF00D; ifa.sel_i = 4'hF;
    @(negedge clk);
    ifa.cyc_i = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      seen = seen | ifa.ack_o | ifa.err_o;
    end
    ifa.stb_i = 1'b0;
    tests_run++;
    if (seen !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_no_resp: response seen=%0b, want 0", seen);
    end
    model_txn(1'b0, 4'd2, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd2, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || d !== 32'h01020304 || l != 3) begin
      tests_failed++;
      $display("FAIL abort_no_write: ack=%0b dat=%08h lat=%0d, want 1 01020304 3", a, d, l);
    end
  endtask

  task automatic test_status();
    logic ea, ee, a, e, t; logic [31:0] ed, d; int l;
    model_txn(1'b1, 4'd15, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b1, 4'd15, 32'h0, 4'h0, a, e, d, l, t);
    for (int i = 0; i < 5; i++) begin
      model_txn(1'b1, 4'(i), 32'(i * 7), 4'hF, ea, ee, ed);
      do_txn(1'b1, 4'(i), 32'(i * 7), 4'hF, a, e, d, l, t);
    end
    model_txn(1'b0, 4'd15, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd15, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || d !== 32'd5) begin
      tests_failed++;
      $display("FAIL status_count: ack=%0b status=%0d, want 1 5", a, d);
    end
    model_txn(1'b1, 4'd15, 32'hFFFFFFFF, 4'h3, ea, ee, ed);
    do_txn(1'b1, 4'd15, 32'hFFFFFFFF, 4'h3, a, e, d, l, t);
    model_txn(1'b0, 4'd15, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd15, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || d !== 32'd0) begin
      tests_failed++;
      $display("FAIL status_clear: ack=%0b status=%0d, want 1 0", a, d);
    end
  endtask

  task automatic test_random();
    logic ea, ee, a, e, t, we; logic [31:0] ed, d, dat; logic [3:0] adr, sel; int l, pick;
    for (int n = 0; n < 40; n++) begin
      pick = int'($urandom_range(0, 9));
      if (pick < 8)       adr = 4'(pick);
      else if (pick == 8) adr = 4'd15;
      else                adr = 4'(8 + $urandom_range(0, 6));
      we  = 1'($urandom_range(0, 1));
      dat = $urandom;
      sel = 4'($urandom_range(0, 15));
      model_txn(we, adr, dat, sel, ea, ee, ed);
      do_txn(we, adr, dat, sel, a, e, d, l, t);
      tests_run++;
      if (a !== ea || e !== ee || d !== ed || l != 3 || t !== 1'b0) begin
        tests_failed++;
        $display("FAIL random_%0d: ack=%0b err=%0b dat=%08h lat=%0d tail=%0b, want %0b %0b %08h 3 0",
                 n, a, e, d, l, t, ea, ee, ed);
      end
    end
  endtask

  // Held request on the zero-latency instance: acks every other cycle.
  task automatic test_back_to_back();
    logic a;
    @(negedge clk);
    ifb.cyc_i = 1'b1; ifb.stb_i = 1'b1; ifb.we_i = 1'b1;
    ifb.adr_i = 4'd1; ifb.dat_i = 32'h5A5A1234; ifb.sel_i = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      a = ifb.ack_o;
      tests_run++;
      if (a !== ((i % 2) == 0) || ifb.err_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL b2b_ack_%0d: ack=%0b err=%0b, want %0b 0", i, a, ifb.err_o, (i % 2) == 0);
      end
    end
    @(negedge clk);
    ifb.we_i = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if (ifb.ack_o !== 1'b1 || ifb.dat_o !== 32'h5A5A1234) begin
      tests_failed++;
      $display("FAIL b2b_read: ack=%0b dat=%08h, want 1 5a5a1234", ifb.ack_o, ifb.dat_o);
    end
    ifb.cyc_i = 1'b0; ifb.stb_i = 1'b0;
    $display("[TB] b2b zero-delay sequence done");
  endtask

  task automatic test_reset_in_delay();
    logic ea, ee, a, e, t; logic [31:0] ed, d; int l;
    model_txn(1'b1, 4'd4, 32'h87654321, 4'hF, ea, ee, ed);
    do_txn(1'b1, 4'd4, 32'h87654321, 4'hF, a, e, d, l, t);
    @(negedge clk);
    ifa.cyc_i = 1'b1; ifa.stb_i = 1'b1; ifa.we_i = 1'b0;
    ifa.adr_i = 4'd4; ifa.sel_i = 4'h0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (ifa.ack_o !== 1'b0 || ifa.err_o !== 1'b0 || ifa.dat_o !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_in_delay: ack=%0b err=%0b dat=%08h, want 0 0 0",
               ifa.ack_o, ifa.err_o, ifa.dat_o);
    end
    ifa.cyc_i = 1'b0; ifa.stb_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_txn(1'b0, 4'd4, 32'h0, 4'h0, ea, ee, ed);
    do_txn(1'b0, 4'd4, 32'h0, 4'h0, a, e, d, l, t);
    tests_run++;
    if (a !== 1'b1 || d !== 32'd0 || l != 3) begin
      tests_failed++;
      $display("FAIL reset_clears_regs: ack=%0b dat=%08h lat=%0d, want 1 0 3", a, d, l);
    end
  endtask

  initial begin
    ifa.cyc_i = 1'b0; ifa.stb_i = 1'b0; ifa.we_i = 1'b0;
    ifa.adr_i = '0;   ifa.dat_i = '0;   ifa.sel_i = '0;
    ifb.cyc_i = 1'b0; ifb.stb_i = 1'b0; ifb.we_i = 1'b0;
    ifb.adr_i = '0;   ifb.dat_i = '0;   ifb.sel_i = '0;
    model_reset();
    test_reset();
    test_basic();
    test_byte_sel();
    test_error();
    test_abort();
    test_status();
    test_random();
    test_back_to_back();
    test_reset_in_delay();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
